// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter: widths, FSM state
// encodings and the read-return tag.
package data_mem_arbiter_pkg;

    localparam int DW_DEF           = 16;
    localparam int AW_DEF           = 6;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef logic [DW_DEF-1:0] data_word_t;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_RUN   = 2'd0;
    localparam arb_state_t ST_FORCE = 2'd1;
    localparam arb_state_t ST_HALT  = 2'd2;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_P    = 2'd1,
        TAG_D    = 2'd2
    } rd_tag_t;

    function automatic rd_tag_t read_tag(input logic p_rd, input logic d_rd);
        if (p_rd) begin
            return TAG_P;
        end
        if (d_rd) begin
            return TAG_D;
        end
        return TAG_NONE;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_starve_ctr.sv
// Starvation guard for the debug port: saturating count of consecutive
// denied cycles and a flag telling the arbiter to force D through next.
module arb_starve_ctr
    import data_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic gnt_i,
    output logic force_o
);

    localparam int            CW      = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || gnt_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // The count includes this cycle's denial, so the STARVE_LIMIT-th waiting cycle is the forced one.
    assign force_o = req_i && !gnt_i && (cnt_d == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data memory between the pipeline (P) and the
// debug loader (D), and steers one-cycle-late read data back to the issuer.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int DW           = DW_DEF,
    parameter int AW           = AW_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          do_branch,
    input  logic          do_halt,
    input  logic          p_req,
    input  logic          p_we,
    input  logic [AW-1:0] p_addr,
    input  logic [DW-1:0] p_wdata,
    output logic          p_gnt,
    output logic          p_rvalid,
    output logic [DW-1:0] p_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t    state_q;
    arb_state_t    state_d;
    rd_tag_t       rd_tag_q;
    rd_tag_t       rd_tag_d;
    logic [DW-1:0] p_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          d_force;

    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .req_i   (d_req),
        .gnt_i   (d_gnt),
        .force_o (d_force)
    );

    // No access is issued while reset is held, so nothing in flight survives it.
    always_comb begin
        p_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst) begin
            case (state_q)
                ST_RUN: begin
                    p_gnt = p_req && !do_branch && !do_halt;
                    d_gnt = d_req && !p_gnt;
                end
                ST_FORCE: begin
                    d_gnt = d_req;
                    p_gnt = p_req && !d_req && !do_branch && !do_halt;
                end
                ST_HALT: begin
                    d_gnt = d_req;
                end
                default: begin
                    p_gnt = 1'b0;
                    d_gnt = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        if (do_halt || (state_q == ST_HALT)) begin
            state_d = ST_HALT;
        end else if (state_q == ST_FORCE) begin
            state_d = ST_RUN;
        end else if (d_force) begin
            state_d = ST_FORCE;
        end
    end

    assign mem_en    = p_gnt || d_gnt;
    assign mem_we    = p_gnt ? p_we    : (d_gnt && d_we);
    assign mem_addr  = p_gnt ? p_addr  : d_addr;
    assign mem_wdata = p_gnt ? p_wdata : d_wdata;

    assign rd_tag_d = read_tag(p_gnt && !p_we, d_gnt && !d_we);

    // A flush in the return cycle still lets the memory read finish but hides it from P.
    assign p_rvalid = rst && (rd_tag_q == TAG_P) && !do_branch;
    assign d_rvalid = rst && (rd_tag_q == TAG_D);
    assign p_rdata  = p_rvalid ? mem_rdata : p_rdata_q;
    assign d_rdata  = d_rvalid ? mem_rdata : d_rdata_q;

    // NOTE: reset is synchronous and active-low; the memory array lives outside, so only control and return registers are cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            rd_tag_q  <= TAG_NONE;
            p_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            rd_tag_q  <= rd_tag_d;
            p_rdata_q <= p_rdata;
            d_rdata_q <= d_rdata;
        end
    end

    grant_exclusive: assert property (@(posedge clk) disable iff (!rst) !(p_gnt && d_gnt));
    halt_blocks_p:   assert property (@(posedge clk) disable iff (!rst) (state_q == ST_HALT) |-> !p_gnt);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: table-driven grant vectors plus a
// read-return scoreboard against a behavioural memory and shadow model.
module tb_data_mem_arbiter;

    localparam int DW = 16;
    localparam int AW = 6;

    typedef struct packed {
        logic          rst;
        logic          br;
        logic          hlt;
        logic          p_req;
        logic          p_we;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_wdata;
        logic          d_req;
        logic          d_we;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
        logic          exp_p;
        logic          exp_d;
    } vec_t;

    typedef struct {
        logic          is_d;
        logic [DW-1:0] data;
    } sb_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          do_branch;
    logic          do_halt;
    logic          p_req;
    logic          p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic          p_gnt;
    logic          p_rvalid;
    logic [DW-1:0] p_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          tb_init;
    logic [DW-1:0] mem       [64];
    logic [DW-1:0] model_mem [64];
    sb_t           sb[$];
    vec_t          tbl[$];
    logic [DW-1:0] last_p;
    logic [DW-1:0] last_d;
    int            n_vec;
    int            n_err;
    int            cur_vec;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .DW           (DW),
        .AW           (AW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .do_branch (do_branch),
        .do_halt   (do_halt),
        .p_req     (p_req),
        .p_we      (p_we),
        .p_addr    (p_addr),
        .p_wdata   (p_wdata),
        .p_gnt     (p_gnt),
        .p_rvalid  (p_rvalid),
        .p_rdata   (p_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [DW-1:0] init_word(input int i);
        return DW'(i * 2);
    endfunction

    // Single-port synchronous memory: read data appears the cycle after the access.
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= init_word(i);
            end
        end else if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    function automatic vec_t mk(input logic rst_v, input logic br, input logic hlt,
                                input logic preq, input logic pwe, input int paddr, input int pwd,
                                input logic dreq, input logic dwe, input int daddr, input int dwd,
                                input logic ep, input logic ed);
        vec_t v;
        v.rst     = rst_v;
        v.br      = br;
        v.hlt     = hlt;
        v.p_req   = preq;
        v.p_we    = pwe;
        v.p_addr  = AW'(paddr);
        v.p_wdata = DW'(pwd);
        v.d_req   = dreq;
        v.d_we    = dwe;
        v.d_addr  = AW'(daddr);
        v.d_wdata = DW'(dwd);
        v.exp_p   = ep;
        v.exp_d   = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL vec %0d %s: got 0x%0h, expected 0x%0h", cur_vec, name, act, exp);
            n_err++;
        end
    endtask

    task automatic apply(input vec_t v);
        sb_t           e;
        logic          exp_pv;
        logic          exp_dv;
        logic [DW-1:0] exp_pd;
        logic [DW-1:0] exp_dd;
        rst       = v.rst;
        do_branch = v.br;
        do_halt   = v.hlt;
        p_req     = v.p_req;
        p_we      = v.p_we;
        p_addr    = v.p_addr;
        p_wdata   = v.p_wdata;
        d_req     = v.d_req;
        d_we      = v.d_we;
        d_addr    = v.d_addr;
        d_wdata   = v.d_wdata;
        @(negedge clk);
        n_vec++;
        check("p_gnt", 32'(p_gnt), 32'(v.exp_p));
        check("d_gnt", 32'(d_gnt), 32'(v.exp_d));
        check("mem_en", 32'(mem_en), 32'(v.exp_p | v.exp_d));
        if (v.exp_p || v.exp_d) begin
            check("mem_we", 32'(mem_we), 32'(v.exp_p ? v.p_we : v.d_we));
            check("mem_addr", 32'(mem_addr), 32'(v.exp_p ? v.p_addr : v.d_addr));
            if (v.exp_p ? v.p_we : v.d_we) begin
                check("mem_wdata", 32'(mem_wdata), 32'(v.exp_p ? v.p_wdata : v.d_wdata));
            end
        end
        exp_pv = 1'b0;
        exp_dv = 1'b0;
        exp_pd = last_p;
        exp_dd = last_d;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (v.rst && !e.is_d && !v.br) begin
                exp_pv = 1'b1;
                exp_pd = e.data;
            end
            if (v.rst && e.is_d) begin
                exp_dv = 1'b1;
                exp_dd = e.data;
            end
        end
        check("p_rvalid", 32'(p_rvalid), 32'(exp_pv));
        check("d_rvalid", 32'(d_rvalid), 32'(exp_dv));
        check("p_rdata", 32'(p_rdata), 32'(exp_pd));
        check("d_rdata", 32'(d_rdata), 32'(exp_dd));
        last_p = exp_pd;
        last_d = exp_dd;
        if (v.rst) begin
            if (v.exp_p) begin
                if (v.p_we) model_mem[v.p_addr] = v.p_wdata;
                else        sb.push_back('{is_d: 1'b0, data: model_mem[v.p_addr]});
            end
            if (v.exp_d) begin
                if (v.d_we) model_mem[v.d_addr] = v.d_wdata;
                else        sb.push_back('{is_d: 1'b1, data: model_mem[v.d_addr]});
            end
        end else begin
            last_p = '0;
            last_d = '0;
        end
        cur_vec++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        cur_vec = 0;
        last_p  = '0;
        last_d  = '0;
        for (int i = 0; i < 64; i++) begin
            model_mem[i] = init_word(i);
        end
        tb_init   = 1'b1;
        rst       = 1'b0;
        do_branch = 1'b0;
        do_halt   = 1'b0;
        p_req     = 1'b0;
        p_we      = 1'b0;
        p_addr    = '0;
        p_wdata   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        @(posedge clk);
        #1;
        tb_init = 1'b0;

        // Reset state, then single P load of mem[5]=10.
        tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(1,0,0, 1,0,5,0, 0,0,0,0, 1,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0));
        // Both requesting for 6 cycles: P,P,P,D(forced),P,P.
        for (int k = 0; k < 6; k++) begin
            tbl.push_back(mk(1,0,0, 1,0,10+k,0, 1,0,20,0, k != 3, k == 3));
        end
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0));
        // P store then D load of the same word.
        tbl.push_back(mk(1,0,0, 1,1,1,7, 0,0,0,0, 1,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 1,0,1,0, 0,1));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0));
        // Top address: load, overwrite by D during the return, reload.
        tbl.push_back(mk(1,0,0, 1,0,63,0, 0,0,0,0, 1,0));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 1,1,63,16'hBEEF, 0,1));
        tbl.push_back(mk(1,0,0, 1,0,63,0, 0,0,0,0, 1,0));
        // Flush: return of P load hidden, P blocked, D still served.
        tbl.push_back(mk(1,0,0, 1,0,2,0, 0,0,0,0, 1,0));
        tbl.push_back(mk(1,1,0, 1,0,3,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(1,1,0, 1,0,3,0, 1,0,4,0, 0,1));
        tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0));
        foreach (tbl[i]) begin
            apply(tbl[i]);
        end

        // Reset during a read return after the starve count has built up.
        apply(mk(1,0,0, 1,0,7,0, 1,0,9,0, 1,0));
        apply(mk(1,0,0, 1,0,8,0, 1,0,9,0, 1,0));
        apply(mk(0,0,0, 1,0,8,0, 1,0,9,0, 0,0));
        for (int k = 0; k < 4; k++) begin
            apply(mk(1,0,0, 1,0,30+k,0, 1,0,40,0, k != 3, k == 3));
        end
        apply(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0));

        // Halt pulse: D only from then on, P locked out until reset.
        apply(mk(1,0,1, 1,0,3,0, 1,0,4,0, 0,1));
        for (int k = 0; k < 3; k++) begin
            apply(mk(1,0,0, 1,0,5,0, 1,0,6+k,0, 0,1));
        end
        apply(mk(1,0,0, 1,1,5,16'h1234, 0,0,0,0, 0,0));
        apply(mk(1,0,0, 1,0,5,0, 0,0,0,0, 0,0));
        apply(mk(0,0,0, 0,0,0,0, 0,0,0,0, 0,0));
        apply(mk(1,0,0, 1,0,5,0, 0,0,0,0, 1,0));
        apply(mk(1,0,0, 0,0,0,0, 0,0,0,0, 0,0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
